// File: rtl/mem_channel_responder.sv
// Multi-channel fixed-latency memory responder with host preload port.
module mem_channel_responder #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 2,
  parameter bit          WRITE_ENABLE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_write_enable,
  input  logic [ADDR_BITS-1:0]    host_write_address,
  input  logic [DATA_BITS-1:0]    host_write_data,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  output logic                    busy
);

  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RBUSY   = 3'd1,
    S_WBUSY   = 3'd2,
    S_RESP    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  logic [DATA_BITS-1:0]    mem [DEPTH];

  state_t                  state_q   [NUM_CHANNELS];
  state_t                  state_d   [NUM_CHANNELS];
  logic [CNT_W-1:0]        cnt_q     [NUM_CHANNELS];
  logic [CNT_W-1:0]        cnt_d     [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    cap_q     [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    cap_d     [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rd_data_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] served_wr_q;
  logic [NUM_CHANNELS-1:0] served_wr_d;
  logic [NUM_CHANNELS-1:0] wr_commit_c;
  logic [NUM_CHANNELS-1:0] rd_ready_d;
  logic [NUM_CHANNELS-1:0] wr_ready_d;
  logic                    busy_d;

  // Array writes; later statements win, so higher channels beat lower ones and all beat the host.
  always_ff @(posedge clk) begin
    if (host_write_enable) mem[host_write_address] <= host_write_data;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (wr_commit_c[ch] && !reset) mem[mem_write_address[ch]] <= mem_write_data[ch];
    end
  end

  // Per-channel next state, counters, captured data and registered output values.
  always_comb begin
    rd_ready_d  = '0;
    wr_ready_d  = '0;
    wr_commit_c = '0;
    served_wr_d = served_wr_q;
    busy_d      = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch]   = state_q[ch];
      cnt_d[ch]     = cnt_q[ch];
      cap_d[ch]     = cap_q[ch];
      rd_data_d[ch] = mem_read_data[ch];
      case (state_q[ch])
        S_IDLE: begin
          if (WRITE_ENABLE && mem_write_valid[ch]) begin
            wr_commit_c[ch] = 1'b1;
            served_wr_d[ch] = 1'b1;
            cnt_d[ch]       = CNT_W'(WRITE_LATENCY - 1);
            state_d[ch]     = S_WBUSY;
          end else if (mem_read_valid[ch]) begin
            cap_d[ch]       = mem[mem_read_address[ch]];
            served_wr_d[ch] = 1'b0;
            cnt_d[ch]       = CNT_W'(READ_LATENCY - 1);
            state_d[ch]     = S_RBUSY;
          end
        end
        S_RBUSY: begin
          if (cnt_q[ch] == '0) begin
            rd_ready_d[ch] = 1'b1;
            rd_data_d[ch]  = cap_q[ch];
            state_d[ch]    = S_RESP;
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
          end
        end
        S_WBUSY: begin
          if (cnt_q[ch] == '0) begin
            wr_ready_d[ch] = 1'b1;
            state_d[ch]    = S_RESP;
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
          end
        end
        S_RESP: state_d[ch] = S_RELEASE;
        S_RELEASE: begin
          // Wait for the served request to drop so it is not taken twice.
          if (served_wr_q[ch] ? !mem_write_valid[ch] : !mem_read_valid[ch]) state_d[ch] = S_IDLE;
        end
        default: state_d[ch] = S_IDLE;
      endcase
      busy_d = busy_d | (state_d[ch] != S_IDLE);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      served_wr_q     <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      busy            <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]       <= S_IDLE;
        cnt_q[ch]         <= '0;
        cap_q[ch]         <= '0;
        mem_read_data[ch] <= '0;
      end
    end else begin
      served_wr_q     <= served_wr_d;
      mem_read_ready  <= rd_ready_d;
      mem_write_ready <= wr_ready_d;
      busy            <= busy_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]       <= state_d[ch];
        cnt_q[ch]         <= cnt_d[ch];
        cap_q[ch]         <= cap_d[ch];
        mem_read_data[ch] <= rd_data_d[ch];
      end
    end
  end

endmodule
